// File: rtl/p32_p4_serializer.sv
// 32-bit word -> 4-bit DAT lane serializer, MSB nibble first; pop at T+1, first nibble at T+2, back-to-back words.
// Stalls (holds all state) while enable is low; waits on an empty FIFO mid-block and flags underrun each cycle.
module p32_p4_serializer #(
   parameter int DATA_W = 32,
   parameter int LANE_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic [7:0]        blk_words,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_pop,
   output logic [LANE_W-1:0] dat_out,
   output logic              dat_valid,
   output logic              busy,
   output logic              block_done,
   output logic              underrun
);

   typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic [2:0]        nib_cnt, nib_cnt_nxt;
   logic [8:0]        words_left, words_left_nxt;
   logic              first_sent, first_sent_nxt;
   logic              pop_req;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         nib_cnt    <= '0;
         words_left <= '0;
         first_sent <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         nib_cnt    <= nib_cnt_nxt;
         words_left <= words_left_nxt;
         first_sent <= first_sent_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      nib_cnt_nxt    = nib_cnt;
      words_left_nxt = words_left;
      first_sent_nxt = first_sent;
      pop_req        = 1'b0;
      dat_out        = '0;
      dat_valid      = 1'b0;
      block_done     = 1'b0;
      underrun       = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               words_left_nxt = (blk_words == 8'd0) ? 9'd256 : {1'b0, blk_words};
               first_sent_nxt = 1'b0;
               state_nxt      = WAIT;
            end
         end
         WAIT: begin
            if (enable && !fifo_empty) begin
               pop_req     = 1'b1;
               shreg_nxt   = fifo_data;
               nib_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end else begin
               // Waiting before the first word of a block is normal start-up, not an underrun
               underrun = fifo_empty && first_sent;
            end
         end
         SHIFT: begin
            if (enable) begin
               dat_valid   = 1'b1;
               dat_out     = shreg[DATA_W-1 -: LANE_W];
               shreg_nxt   = shreg << LANE_W;
               nib_cnt_nxt = nib_cnt + 3'd1;
               if (nib_cnt == 3'd7) begin
                  if (words_left != 9'd0)
                     words_left_nxt = words_left - 9'd1;
                  first_sent_nxt = 1'b1;
                  if (words_left == 9'd1) begin
                     state_nxt = DONE;
                  end else if (!fifo_empty) begin
                     // Reload in the last-nibble cycle so words stream with no gap
                     pop_req     = 1'b1;
                     shreg_nxt   = fifo_data;
                     nib_cnt_nxt = '0;
                  end else begin
                     state_nxt = WAIT;
                  end
               end
            end
         end
         DONE: begin
            block_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fifo_pop = pop_req && reset;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_p32_p4_serializer.sv
// Scoreboarded bench for p32_p4_serializer: FIFO model, nibble reference queue, directed and random blocks.
module tb_p32_p4_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  blk_words = 8'd0;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_data = 32'h0;
   logic        fifo_pop, dat_valid, busy, block_done, underrun;
   logic [3:0]  dat_out;

   p32_p4_serializer dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .blk_words(blk_words),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
      .dat_out(dat_out), .dat_valid(dat_valid), .busy(busy),
      .block_done(block_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   logic [31:0] fifo_q[$];
   logic [31:0] all_words[$];
   logic [3:0]  exp_q[$];
   int next_word = 0, pending = 0;
   int cyc = 0, pop_cnt = 0, done_cnt = 0, und_cnt = 0, val_cnt = 0;
   int first_v = -1, last_v = -1, done_cyc = -1, idle_cyc = -1, t_start = 0;
   int pop_cycs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: a block of N words emits the next N unclaimed FIFO words, 8 nibbles each, MSB first
   function automatic void assign_words();
      while (pending > 0 && next_word < all_words.size()) begin
         logic [31:0] w;
         w = all_words[next_word];
         for (int k = 7; k >= 0; k--)
            exp_q.push_back(4'((w >> (4 * k)) & 32'hF));
         next_word++;
         pending--;
      end
   endfunction

   function automatic void push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      all_words.push_back(w);
      assign_words();
   endfunction

   always @(posedge clk) cyc++;

   // FIFO outputs follow the queue shortly after each edge, so the DUT always samples a stable head
   always @(posedge clk) begin
      #2;
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
   end

   always @(negedge clk) begin
      if (!reset) check("pop_during_reset", fifo_pop, 1'b0);
      if (dat_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_nibble: got 0x%0h, expected no dat_valid", dat_out);
         end else begin
            check("nibble", dat_out, exp_q.pop_front());
         end
         check("valid_needs_enable", enable, 1'b1);
         val_cnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end else begin
         check("dat_out_idle_zero", dat_out, 4'h0);
      end
      if (fifo_pop) begin
         check("pop_when_empty", fifo_empty, 1'b0);
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_cnt++;
         pop_cycs.push_back(cyc);
      end
      if (block_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (underrun) und_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      pop_cnt = 0; done_cnt = 0; und_cnt = 0; val_cnt = 0;
      first_v = -1; last_v = -1; done_cyc = -1; idle_cyc = -1;
      pop_cycs.delete();
   endtask

   task automatic do_start(input int n);
      t_start   = cyc;
      start     = 1'b1;
      blk_words = 8'(n);
      pending  += (n == 0) ? 256 : n;
      assign_words();
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (!busy) begin
            idle_cyc = cyc;
            step();
            return;
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
      step();
   endtask

   task automatic block_checks(input string name, input int pops, input int nibs, input int unds);
      check({name, "_pops"}, pop_cnt, pops);
      check({name, "_nibbles"}, val_cnt, nibs);
      check({name, "_block_done"}, done_cnt, 1);
      check({name, "_underruns"}, und_cnt, unds);
      check({name, "_scoreboard_left"}, exp_q.size(), 0);
   endtask

   task automatic timing_checks(input string name);
      check({name, "_contiguous"}, last_v - first_v + 1, val_cnt);
      check({name, "_done_after_last"}, done_cyc, last_v + 1);
      check({name, "_busy_falls"}, idle_cyc, done_cyc + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, pushed, n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_dat_valid", dat_valid, 1'b0);
      check("rst_dat_out", dat_out, 4'h0);
      check("rst_fifo_pop", fifo_pop, 1'b0);
      check("rst_block_done", block_done, 1'b0);
      check("rst_underrun", underrun, 1'b0);
      reset  = 1'b1;
      enable = 1'b1;
      step();

      // Single word
      clear_stats();
      push_word(32'h1234_ABCD);
      do_start(1);
      wait_idle(40, "single");
      block_checks("single", 1, 8, 0);
      timing_checks("single");
      check("single_first_nibble_lat", first_v, t_start + 2);
      if (pop_cycs.size() > 0) check("single_pop_lat", pop_cycs[0], t_start + 1);

      // Back-to-back words
      clear_stats();
      push_word(32'h0123_4567);
      push_word(32'h89AB_CDEF);
      push_word(32'hFEDC_BA98);
      do_start(3);
      wait_idle(80, "b2b");
      block_checks("b2b", 3, 24, 0);
      timing_checks("b2b");
      if (pop_cycs.size() == 3) begin
         check("b2b_pop_gap1", pop_cycs[1] - pop_cycs[0], 8);
         check("b2b_pop_gap2", pop_cycs[2] - pop_cycs[1], 8);
      end

      // Underrun: late first word (no underrun), then second word 5 cycles late
      clear_stats();
      do_start(2);
      step();
      step();
      check("underrun_before_first_pop", und_cnt, 0);
      push_word(32'h5A5A_C3C3);
      repeat (14) step();
      push_word(32'h0F1E_2D3C);
      wait_idle(60, "underrun");
      block_checks("underrun", 2, 16, 5);

      // Enable gating
      clear_stats();
      push_word(32'hCAFE_F00D);
      do_start(1);
      for (int i = 0; i < 60 && done_cnt == 0; i++) begin
         enable = (i % 2 == 0);
         step();
      end
      enable = 1'b1;
      wait_idle(40, "enable_gate");
      block_checks("enable_gate", 1, 8, 0);

      // Reset during the 4th nibble of a 4-word block
      clear_stats();
      base = all_words.size();
      for (int i = 0; i < 4; i++) push_word(32'hA000_0001 + 32'(i) * 32'h0111_1110);
      do_start(4);
      repeat (4) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      exp_q.delete();
      pending   = 0;
      next_word = base + 1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_dat_valid", dat_valid, 1'b0);
      check("midrst_dat_out", dat_out, 4'h0);
      check("midrst_block_done", block_done, 1'b0);
      check("midrst_underrun", underrun, 1'b0);
      repeat (5) step();
      check("midrst_nibbles_before", val_cnt, 4);
      check("midrst_pops_total", pop_cnt, 1);
      clear_stats();
      do_start(1);
      wait_idle(40, "after_reset");
      block_checks("after_reset", 1, 8, 0);

      // blk_words = 0 means 256; starts while busy are ignored
      clear_stats();
      for (int i = 0; i < 257; i++) push_word($urandom);
      do_start(0);
      repeat (3) begin
         repeat (300) step();
         start     = 1'b1;
         blk_words = 8'd5;
         step();
         start = 1'b0;
      end
      wait_idle(3000, "len256");
      block_checks("len256", 256, 2048, 0);
      timing_checks("len256");

      // Random blocks with random enable and FIFO arrival
      for (int b = 0; b < 20; b++) begin
         clear_stats();
         n = $urandom_range(1, 6);
         pushed = 0;
         do_start(n);
         for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            enable = ($urandom % 4 != 0);
            if (pushed < n && $urandom % 3 == 0) begin
               push_word($urandom);
               pushed++;
            end
            step();
         end
         while (pushed < n) begin
            push_word($urandom);
            pushed++;
         end
         enable = 1'b1;
         wait_idle(200, "random");
         check("random_nibbles", val_cnt, 8 * n);
         check("random_block_done", done_cnt, 1);
         check("random_scoreboard_left", exp_q.size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
